// File: rtl/sfq_dfft_array.sv
// sfq_dfft_array: WIDTH-channel bank of DEPTH-stage SFQ DFF pipelines.
// A shared clock-pulse strobe reads out every channel at the same time.
// Pulses are modelled as one-cycle-high levels on the fabric clock.
// Ports:
//   clk, rst_n  fabric clock; asynchronous active-low reset
//   set         per-channel data pulse (stored in stage 0)
//   clr         per-channel stage-0 clear; only acts when NDRO=1
//   clk_pulse   readout strobe shared by all channels
//   out         per-channel output pulse, high for one cycle
//   err_double  sticky per channel: set arrived while stage 0 was full
//   err_race    one-cycle flag: set/clr coincided with clk_pulse
//   pulse_cnt   saturating count of all output pulses since reset

// One channel: stage shift register, output pulse and double-set flag.
module sfq_dfft_lane #(
    parameter int DEPTH = 2,
    parameter int NDRO  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    input  logic clk_pulse,
    output logic out_nxt,
    output logic out,
    output logic err_double,
    output logic race
);
    logic [DEPTH-1:0] s, s_nxt;
    logic             clr_eff;
    logic             dbl_hit;

    // clr has no effect in destructive mode
    assign clr_eff = (NDRO != 0) && clr;

    always_comb begin
        s_nxt = s;
        if (clk_pulse) begin
            for (int k = 1; k < DEPTH; k++) s_nxt[k] = s[k-1];
        end
        // Stage 0 priority: clr, then a new pulse, then destructive readout.
        // A set coincident with readout lands after the shift.
        if (clr_eff)                       s_nxt[0] = 1'b0;
        else if (set)                      s_nxt[0] = 1'b1;
        else if (clk_pulse && NDRO == 0)   s_nxt[0] = 1'b0;
    end

    assign out_nxt = clk_pulse & s[DEPTH-1];
    // A set during readout is not a double: the old pulse has already left.
    assign dbl_hit = set & s[0] & ~clk_pulse & ~clr_eff;
    assign race    = clk_pulse & (set | clr_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            out        <= 1'b0;
            err_double <= 1'b0;
        end else begin
            s   <= s_nxt;
            out <= out_nxt;
            if (dbl_hit) err_double <= 1'b1;
        end
    end
endmodule

module sfq_dfft_array #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int NDRO  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             clk_pulse,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] err_double,
    output logic             err_race,
    output logic [CNT_W-1:0] pulse_cnt
);
    // Sum width large enough to hold count + popcount without overflow
    localparam int SW = CNT_W + $clog2(WIDTH + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] race;
    logic [SW-1:0]    pop;
    logic [SW-1:0]    sum;

    for (genvar c = 0; c < WIDTH; c++) begin : g_lane
        sfq_dfft_lane #(.DEPTH(DEPTH), .NDRO(NDRO)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .set        (set[c]),
            .clr        (clr[c]),
            .clk_pulse  (clk_pulse),
            .out_nxt    (out_nxt[c]),
            .out        (out[c]),
            .err_double (err_double[c]),
            .race       (race[c])
        );
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < WIDTH; c++) pop = pop + SW'(out_nxt[c]);
        sum = SW'(pulse_cnt) + pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_race  <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            err_race  <= |race;
            pulse_cnt <= (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_sfq_dfft_array.sv
// Directed bench for sfq_dfft_array. Three instances cover the
// destructive DEPTH=2 default, NDRO=1/DEPTH=1 and a 3-bit counter.
module tb_sfq_dfft_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: WIDTH=4 DEPTH=2 NDRO=0 CNT_W=8
    logic [3:0] a_set = '0, a_clr = '0, a_out, a_dbl;
    logic       a_cp = 1'b0, a_race;
    logic [7:0] a_cnt;
    // B: WIDTH=4 DEPTH=1 NDRO=1 CNT_W=8
    logic [3:0] b_set = '0, b_clr = '0, b_out, b_dbl;
    logic       b_cp = 1'b0, b_race;
    logic [7:0] b_cnt;
    // C: WIDTH=4 DEPTH=1 NDRO=1 CNT_W=3
    logic [3:0] c_set = '0, c_clr = '0, c_out, c_dbl;
    logic       c_cp = 1'b0, c_race;
    logic [2:0] c_cnt;

    sfq_dfft_array #(.WIDTH(4), .DEPTH(2), .NDRO(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .set(a_set), .clr(a_clr), .clk_pulse(a_cp),
        .out(a_out), .err_double(a_dbl), .err_race(a_race), .pulse_cnt(a_cnt));
    sfq_dfft_array #(.WIDTH(4), .DEPTH(1), .NDRO(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .set(b_set), .clr(b_clr), .clk_pulse(b_cp),
        .out(b_out), .err_double(b_dbl), .err_race(b_race), .pulse_cnt(b_cnt));
    sfq_dfft_array #(.WIDTH(4), .DEPTH(1), .NDRO(1), .CNT_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .set(c_set), .clr(c_clr), .clk_pulse(c_cp),
        .out(c_out), .err_double(c_dbl), .err_race(c_race), .pulse_cnt(c_cnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are held across one rising edge, then checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] set;
        logic [3:0] clr;
        logic       cp;
        logic [3:0] out;
        logic [3:0] dbl;
        logic       race;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[20];

    initial begin
        // Instance A sequence: basic latency, double set, race, clr ignored.
        tv[0]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tv[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tv[2]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tv[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tv[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tv[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0000, 1'b0, 8'd2};
        tv[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd2};
        tv[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd2};
        tv[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd2};
        tv[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'd2};
        tv[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 8'd3};
        tv[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd3};
        tv[12] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd3};
        tv[13] = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b1, 8'd3};
        tv[14] = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0010, 1'b0, 8'd4};
        tv[15] = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0010, 1'b0, 8'd5};
        tv[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd5};
        tv[17] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd5};
        tv[18] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'd5};
        tv[19] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0010, 1'b0, 8'd6};

        // Reset held for 3 cycles; outputs must be zero throughout.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_a_out", 32'(a_out), 32'd0);
            chk("rst_a_cnt", 32'(a_cnt), 32'd0);
            chk("rst_b_flags", 32'({b_dbl, b_race}), 32'd0);
            chk("rst_c_cnt", 32'(c_cnt), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            a_set = tv[i].set; a_clr = tv[i].clr; a_cp = tv[i].cp;
            step();
            a_set = '0; a_clr = '0; a_cp = 1'b0;
            chk($sformatf("a_out[%0d]", i),  32'(a_out),  32'(tv[i].out));
            chk($sformatf("a_dbl[%0d]", i),  32'(a_dbl),  32'(tv[i].dbl));
            chk($sformatf("a_race[%0d]", i), 32'(a_race), 32'(tv[i].race));
            chk($sformatf("a_cnt[%0d]", i),  32'(a_cnt),  32'(tv[i].cnt));
        end

        // B: NDRO=1, DEPTH=1 - stage 0 survives readout until clr.
        b_set = 4'b0001; step(); b_set = '0;
        chk("b_set_out", 32'(b_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b_cp = 1'b1; step(); b_cp = 1'b0;
            chk($sformatf("b_ndro_out%0d", i), 32'(b_out), 32'b0001);
            step();
            chk($sformatf("b_ndro_idle%0d", i), 32'(b_out), 32'd0);
        end
        b_clr = 4'b0001; step(); b_clr = '0;
        b_cp = 1'b1; step(); b_cp = 1'b0;
        chk("b_after_clr_out", 32'(b_out), 32'd0);
        chk("b_cnt3", 32'(b_cnt), 32'd3);
        // clr and set together: clr wins, no double flagged
        b_set = 4'b0001; b_clr = 4'b0001; step(); b_set = '0; b_clr = '0;
        chk("b_clrset_dbl", 32'(b_dbl), 32'd0);
        b_cp = 1'b1; step(); b_cp = 1'b0;
        chk("b_clrset_out", 32'(b_out), 32'd0);
        // double set on a retained stage
        b_set = 4'b0001; step();
        chk("b_dbl_first", 32'(b_dbl), 32'd0);
        step(); b_set = '0;
        chk("b_dbl_second", 32'(b_dbl), 32'b0001);
        // clr with readout: old value emitted, stage cleared, race flagged
        b_clr = 4'b0001; b_cp = 1'b1; step(); b_clr = '0; b_cp = 1'b0;
        chk("b_clrcp_out", 32'(b_out), 32'b0001);
        chk("b_clrcp_race", 32'(b_race), 32'd1);
        chk("b_clrcp_cnt", 32'(b_cnt), 32'd4);
        b_cp = 1'b1; step(); b_cp = 1'b0;
        chk("b_cleared_out", 32'(b_out), 32'd0);
        chk("b_race_drop", 32'(b_race), 32'd0);
        chk("b_dbl_sticky", 32'(b_dbl), 32'b0001);

        // C: 3-bit counter saturates at 7
        c_set = 4'b1111; step(); c_set = '0;
        c_cp = 1'b1; step();
        chk("c_out", 32'(c_out), 32'b1111);
        chk("c_cnt4", 32'(c_cnt), 32'd4);
        step();
        chk("c_cnt7", 32'(c_cnt), 32'd7);
        step(); c_cp = 1'b0;
        chk("c_cnt_hold", 32'(c_cnt), 32'd7);

        // A: reset mid-pipeline discards the stored pulses
        a_set = 4'b1111; step(); a_set = '0;
        a_cp = 1'b1; step(); a_cp = 1'b0;
        rst_n = 1'b0; #1;
        chk("mid_rst_cnt_async", 32'(a_cnt), 32'd0);
        chk("mid_rst_dbl_async", 32'(a_dbl), 32'd0);
        step();
        rst_n = 1'b1;
        a_cp = 1'b1; step();
        chk("mid_rst_out1", 32'(a_out), 32'd0);
        step(); a_cp = 1'b0;
        chk("mid_rst_out2", 32'(a_out), 32'd0);
        chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
        chk("mid_rst_race", 32'(a_race), 32'd0);
        chk("mid_rst_dbl", 32'(a_dbl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
